// File: rtl/ldst_dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// ldst_dmem_responder_pkg
// Shared load/store protocol definitions used by the data-memory responder,
// its response queue and the request/response interfaces.
//   RV_XLEN        : data/address width
//   LDST_STRB_W    : byte strobes per word
//   ldst_req_pkt_t : request payload (addr, st, data, strobe)
//   ldst_rsp_pkt_t : response payload (data)
//   ldst_byte_en() : LSB-aligned strobe moved to the byte offset inside a word
// ----------------------------------------------------------------------------
package ldst_dmem_responder_pkg;

    localparam int RV_XLEN     = 32;
    localparam int LDST_STRB_W = RV_XLEN / 8;

    typedef struct packed {
        logic [RV_XLEN-1:0]     addr;
        logic                   st;
        logic [RV_XLEN-1:0]     data;
        logic [LDST_STRB_W-1:0] strobe;
    } ldst_req_pkt_t;

    typedef struct packed {
        logic [RV_XLEN-1:0] data;
    } ldst_rsp_pkt_t;

    // Strobe bits pushed past the top byte fall off; they never wrap into
    // the next word.
    function automatic logic [LDST_STRB_W-1:0] ldst_byte_en(
        input logic [LDST_STRB_W-1:0] strobe,
        input logic [1:0]             off
    );
        return strobe << off;
    endfunction

endpackage

// File: rtl/ldst_if.sv
// ----------------------------------------------------------------------------
// ldst_req_if_t / ldst_rsp_if_t
// Request and response channels between the execute stage and data memory.
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where vld & rdy are both 1; once vld is raised the sender holds vld and pkt
// stable until that edge, and rdy never depends combinationally on vld.
//   mst modport : drives vld/pkt, samples rdy
//   slv modport : samples vld/pkt, drives rdy
// ----------------------------------------------------------------------------
interface ldst_req_if_t;
    import ldst_dmem_responder_pkg::*;
    logic          vld;
    logic          rdy;
    ldst_req_pkt_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface ldst_rsp_if_t;
    import ldst_dmem_responder_pkg::*;
    logic          vld;
    logic          rdy;
    ldst_rsp_pkt_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

// File: rtl/ldst_rsp_fifo.sv
// ----------------------------------------------------------------------------
// ldst_rsp_fifo
// Synchronous first-word-fall-through queue. When nothing is stored, a pushed
// word is visible on o_dout in the same cycle and can be popped straight
// through without occupying a slot.
//   clk, rst_n : clock, synchronous active-low reset (pointers/count only)
//   i_push     : write i_din this cycle
//   i_pop      : consume the current head (only when !o_empty)
//   i_din      : write data
//   o_dout     : head of queue
//   o_full     : all DEPTH slots occupied
//   o_empty    : no head available this cycle
// ----------------------------------------------------------------------------
module ldst_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_stored_empty;
    logic             w_store;
    logic             w_deq;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_stored_empty = (r_count == '0);
    assign o_full         = (r_count == CW'(DEPTH));
    assign o_empty        = w_stored_empty & ~i_push;
    assign o_dout         = w_stored_empty ? i_din : r_mem[r_rd_ptr];

    // A push that is popped in the same cycle with nothing stored bypasses
    // the storage entirely.
    assign w_store = i_push & ~(i_pop & w_stored_empty);
    assign w_deq   = i_pop & ~w_stored_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_deq)   r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_store, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/ldst_dmem_responder.sv
// ----------------------------------------------------------------------------
// ldst_dmem_responder
// Memory-side responder for the load/store channels. Owns a word-organised
// synchronous array, applies byte strobes at addr[1:0], and returns exactly
// one in-order response per accepted request (stores answer with data 0).
//   clk, rst_n   : clock, synchronous active-low reset
//   ldst_req_slv : request channel (vld/pkt in, rdy out)
//   ldst_rsp_mst : response channel (vld/pkt out, rdy in)
//   o_dbg_cnt    : number of outstanding transactions
// ----------------------------------------------------------------------------
module ldst_dmem_responder
    import ldst_dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LAT      = 1,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ldst_req_if_t.slv                      ldst_req_slv,
    ldst_rsp_if_t.mst                      ldst_rsp_mst,
    output logic [$clog2(RSP_DEPTH+1)-1:0] o_dbg_cnt
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int LAST  = RD_LAT - 1;

    logic [RV_XLEN-1:0]     r_mem [DEPTH_WORDS];
    logic [CNT_W-1:0]       r_cnt;
    logic [RD_LAT-1:0]      r_vld;
    logic [RD_LAT-1:0]      r_st;
    logic [1:0]             r_off  [RD_LAT];
    logic [RV_XLEN-1:0]     r_word [RD_LAT];

    logic                   w_req_hsk;
    logic                   w_rsp_hsk;
    logic [AW-1:0]          w_idx;
    logic [1:0]             w_off;
    logic [LDST_STRB_W-1:0] w_be;
    logic [RV_XLEN-1:0]     w_wdata;
    logic [RV_XLEN-1:0]     w_fmt;
    logic [RV_XLEN-1:0]     w_fifo_dout;
    logic                   w_fifo_empty;
    logic                   w_fifo_full_unused;
    logic                   w_unused_addr;

    // Only rst_n and the registered count gate rdy; the count already covers
    // every slot of the response path, so the queue can never overflow.
    assign ldst_req_slv.rdy = rst_n & (r_cnt < CNT_W'(RSP_DEPTH));
    assign w_req_hsk        = ldst_req_slv.vld & ldst_req_slv.rdy;
    assign w_rsp_hsk        = ldst_rsp_mst.vld & ldst_rsp_mst.rdy;

    // Upper address bits alias onto the array.
    assign w_idx         = ldst_req_slv.pkt.addr[AW+1:2];
    assign w_off         = ldst_req_slv.pkt.addr[1:0];
    assign w_unused_addr = ^ldst_req_slv.pkt.addr[RV_XLEN-1:AW+2];
    assign w_be          = ldst_byte_en(ldst_req_slv.pkt.strobe, w_off);
    assign w_wdata       = ldst_req_slv.pkt.data << {w_off, 3'b000};

    always_ff @(posedge clk) begin
        if (w_req_hsk && ldst_req_slv.pkt.st) begin
            for (int b = 0; b < LDST_STRB_W; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    // Stage 0 is the synchronous array read at the accepting edge; later
    // stages only add latency. One request per cycle means a load never
    // shares an edge with a store, so no forwarding is needed.
    always_ff @(posedge clk) begin
        r_word[0] <= r_mem[w_idx];
        r_off[0]  <= w_off;
        r_st[0]   <= ldst_req_slv.pkt.st;
        for (int s = 1; s < RD_LAT; s++) begin
            r_word[s] <= r_word[s-1];
            r_off[s]  <= r_off[s-1];
            r_st[s]   <= r_st[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_req_hsk;
            for (int s = 1; s < RD_LAT; s++) r_vld[s] <= r_vld[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_req_hsk, w_rsp_hsk})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Loads return the addressed byte in bit 0 with zeros shifted in on top.
    assign w_fmt = r_st[LAST] ? '0 : (r_word[LAST] >> {r_off[LAST], 3'b000});

    ldst_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RV_XLEN)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_vld[LAST]),
        .i_pop   (w_rsp_hsk),
        .i_din   (w_fmt),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full_unused),
        .o_empty (w_fifo_empty)
    );

    assign ldst_rsp_mst.vld      = ~w_fifo_empty;
    assign ldst_rsp_mst.pkt.data = ldst_rsp_mst.vld ? w_fifo_dout : '0;
    assign o_dbg_cnt             = r_cnt;

endmodule

// File: tb/tb_ldst_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_ldst_dmem_responder
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized request stream checked every cycle against a byte-level memory
// model and an in-order expected-response queue.
// ----------------------------------------------------------------------------
module tb_ldst_dmem_responder;
    import ldst_dmem_responder_pkg::*;

    localparam int DEPTH_WORDS = 1024;
    localparam int RD_LAT      = 1;
    localparam int RSP_DEPTH   = 2;
    localparam int CNT_W       = $clog2(RSP_DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] dbg_cnt;

    ldst_req_if_t req_if ();
    ldst_rsp_if_t rsp_if ();

    ldst_dmem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .RD_LAT      (RD_LAT),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ldst_req_slv (req_if),
        .ldst_rsp_mst (rsp_if),
        .o_dbg_cnt    (dbg_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] model_mem [DEPTH_WORDS];
    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [31:0] rsp_log[$];
    int          rsp_cyc_log[$];
    int          acc_cyc_log[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          rst_low_prev = 1'b0;
    bit          rand_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-level reference: store moves strobe byte b to byte b+off when it
    // still lands inside the word; load returns bytes off..3 at the bottom.
    function automatic logic [31:0] model_access(input logic [31:0] addr, input logic st,
                                                 input logic [31:0] data, input logic [3:0] strobe);
        int          idx;
        int          off;
        logic [31:0] res;
        idx = int'((addr >> 2) % DEPTH_WORDS);
        off = int'(addr % 4);
        res = '0;
        if (st) begin
            for (int b = 0; b < 4; b++)
                if (strobe[b] && (b + off < 4)) model_mem[idx][8*(b+off) +: 8] = data[8*b +: 8];
        end else begin
            for (int b = 0; b + off < 4; b++) res[8*b +: 8] = model_mem[idx][8*(b+off) +: 8];
        end
        return res;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit eligible;
        cyc++;
        if (!rst_n) begin
            check("rst_req_rdy", {31'b0, req_if.rdy}, 32'd0);
            if (rst_low_prev) begin
                check("rst_rsp_vld", {31'b0, rsp_if.vld}, 32'd0);
                check("rst_rsp_data", rsp_if.pkt.data, 32'd0);
            end
            exp_q.delete();
            exp_cyc_q.delete();
        end else begin
            if (rst_low_prev) check("post_rst_data", rsp_if.pkt.data, 32'd0);
            check("req_rdy", {31'b0, req_if.rdy}, {31'b0, exp_q.size() < RSP_DEPTH});
            check("dbg_cnt", 32'(dbg_cnt), 32'(exp_q.size()));
            eligible = (exp_q.size() > 0) && (exp_cyc_q[0] <= cyc);
            check("rsp_vld", {31'b0, rsp_if.vld}, {31'b0, eligible});
            if (eligible) check("rsp_data", rsp_if.pkt.data, exp_q[0]);
            if (rsp_if.vld && rsp_if.rdy && eligible) begin
                rsp_log.push_back(rsp_if.pkt.data);
                rsp_cyc_log.push_back(cyc);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (req_if.vld && req_if.rdy) begin
                exp_q.push_back(model_access(req_if.pkt.addr, req_if.pkt.st,
                                             req_if.pkt.data, req_if.pkt.strobe));
                exp_cyc_q.push_back(cyc + RD_LAT);
                acc_cyc_log.push_back(cyc);
            end
        end
        rst_low_prev = !rst_n;
    end

    // ---------------- driver tasks ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rsp_log.delete();
        rsp_cyc_log.delete();
        acc_cyc_log.delete();
    endtask

    task automatic do_req(input logic [31:0] addr, input logic st,
                          input logic [31:0] data, input logic [3:0] strobe);
        bit acc;
        acc = 1'b0;
        req_if.vld        = 1'b1;
        req_if.pkt.addr   = addr;
        req_if.pkt.st     = st;
        req_if.pkt.data   = data;
        req_if.pkt.strobe = strobe;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = req_if.rdy;
            sync();
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_accept_timeout: got no accept, expected accept for addr 0x%08h", addr);
        end
        req_if.vld = 1'b0;
    endtask

    task automatic wait_rsps(input int n);
        for (int i = 0; i < 200 && rsp_log.size() < n; i++) sync();
        check("rsp_count", 32'(rsp_log.size()), 32'(n));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] addr;
        req_if.vld = 1'b0;
        req_if.pkt = '0;
        rsp_if.rdy = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_release", {31'b0, req_if.rdy}, 32'd1);
        check("cnt_after_release", 32'(dbg_cnt), 32'd0);
        sync();

        // Give words 0..15 known contents.
        for (int i = 0; i < 16; i++) do_req(32'(i * 4), 1'b1, $urandom, 4'hF);
        wait_rsps(16);
        sync();

        // Word write then read.
        clear_logs();
        do_req(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        do_req(32'h10, 1'b0, 32'h0, 4'h0);
        wait_rsps(2);
        if (rsp_log.size() >= 2) begin
            check("t1_store_rsp", rsp_log[0], 32'h0);
            check("t1_load_rsp", rsp_log[1], 32'hDEADBEEF);
            check("t1_load_latency", 32'(rsp_cyc_log[1] - acc_cyc_log[1]), 32'(RD_LAT));
        end

        // Byte store at offset 3.
        clear_logs();
        do_req(32'h13, 1'b1, 32'h000000A5, 4'h1);
        do_req(32'h10, 1'b0, 32'h0, 4'h0);
        do_req(32'h13, 1'b0, 32'h0, 4'h0);
        wait_rsps(3);
        if (rsp_log.size() >= 3) begin
            check("t2_load_word", rsp_log[1], 32'hA5ADBEEF);
            check("t2_load_off3", rsp_log[2], 32'h000000A5);
        end

        // Halfword at offset 2, then truncated halfword at offset 3.
        clear_logs();
        do_req(32'h20, 1'b1, 32'hCAFEF00D, 4'hF);
        do_req(32'h22, 1'b1, 32'h00001234, 4'h3);
        do_req(32'h20, 1'b0, 32'h0, 4'h0);
        do_req(32'h23, 1'b1, 32'h00005678, 4'h3);
        do_req(32'h20, 1'b0, 32'h0, 4'h0);
        wait_rsps(5);
        if (rsp_log.size() >= 5) begin
            check("t3_half_off2", rsp_log[2], 32'h1234F00D);
            check("t3_half_off3_trunc", rsp_log[4], 32'h7834F00D);
        end

        // Backpressure: only RSP_DEPTH loads get in while rsp.rdy is low.
        clear_logs();
        rsp_if.rdy = 1'b0;
        fork
            begin
                do_req(32'h10, 1'b0, 32'h0, 4'h0);
                do_req(32'h13, 1'b0, 32'h0, 4'h0);
                do_req(32'h20, 1'b0, 32'h0, 4'h0);
                do_req(32'h11, 1'b0, 32'h0, 4'h0);
            end
            begin
                repeat (8) @(negedge clk);
                #1;
                check("bp_accepted", 32'(acc_cyc_log.size()), 32'(RSP_DEPTH));
                check("bp_req_rdy_low", {31'b0, req_if.rdy}, 32'd0);
                sync();
                rsp_if.rdy = 1'b1;
            end
        join
        wait_rsps(4);
        if (rsp_log.size() >= 4 && acc_cyc_log.size() >= 3) begin
            check("bp_rsp0", rsp_log[0], 32'hA5ADBEEF);
            check("bp_rsp1", rsp_log[1], 32'h000000A5);
            check("bp_rsp2", rsp_log[2], 32'h7834F00D);
            check("bp_rsp3", rsp_log[3], 32'h00A5ADBE);
            check("bp_rdy_return", 32'(acc_cyc_log[2] - rsp_cyc_log[0]), 32'd1);
        end

        // Reset with two transactions outstanding.
        sync();
        clear_logs();
        rsp_if.rdy = 1'b0;
        do_req(32'h10, 1'b0, 32'h0, 4'h0);
        do_req(32'h20, 1'b0, 32'h0, 4'h0);
        check("pre_rst_cnt", 32'(dbg_cnt), 32'd2);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_rsp_vld", {31'b0, rsp_if.vld}, 32'd0);
        check("mid_rst_cnt", 32'(dbg_cnt), 32'd0);
        sync();
        rsp_if.rdy = 1'b1;
        repeat (10) sync();
        check("mid_rst_no_stale", 32'(rsp_log.size()), 32'd0);
        do_req(32'h10, 1'b0, 32'h0, 4'h0);
        wait_rsps(1);
        if (rsp_log.size() >= 1) check("mid_rst_mem_kept", rsp_log[0], 32'hA5ADBEEF);

        // Randomized traffic with random response backpressure and aliasing.
        sync();
        clear_logs();
        fork
            begin
                for (int n = 0; n < 400; n++) begin
                    addr = ($urandom & 32'hFFFF_F000)
                         | (32'($urandom_range(0, 15)) << 2)
                         | 32'($urandom_range(0, 3));
                    do_req(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 3) == 0) sync();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    sync();
                    rsp_if.rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_if.rdy = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) sync();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) sync();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ldst_dmem_responder.md
# ldst_dmem_responder

Data-memory responder for the load/store request/response protocol. It sits at the memory end of the `ldst_req_if_t`/`ldst_rsp_if_t` pair that the execute stage drives. It owns a word-organised synchronous data array and applies LSB-aligned strobes at the byte offset given by `addr[1:0]`. It returns exactly one in-order response per accepted request, stores included, and supports up to `RSP_DEPTH` outstanding transactions.

## Interface
- `DEPTH_WORDS`, 1024: array depth in 32-bit words, power of two.
- `RD_LAT`, 1: cycles from request accept to earliest response valid; must be ≥1.
- `RSP_DEPTH`, 2: maximum outstanding transactions, and the response queue depth; must be ≥1.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ldst_req_slv`  `ldst_req_if_t.slv`  —  request channel.
  - `vld` in.
  - `rdy` out.
  - `pkt.addr[RV_XLEN-1:0]` in.
  - `pkt.st` in.
  - `pkt.data[RV_XLEN-1:0]` in.
  - `pkt.strobe[3:0]` in.
- `ldst_rsp_mst`  `ldst_rsp_if_t.mst`  —  response channel.
  - `vld` out.
  - `rdy` in.
  - `pkt.data[RV_XLEN-1:0]` out.

## Operation
- Handshakes:
  - Request handshake (`req_hsk`) = `req.vld & req.rdy`.
  - Response handshake (`rsp_hsk`) = `rsp.vld & rsp.rdy`.
  - At most one of each per cycle.
- Outstanding counter `cnt`, width `$clog2(RSP_DEPTH+1)`:
  - +1 on `req_hsk`.
  - −1 on `rsp_hsk`.
  - Unchanged when both occur.
- `req.rdy` = `rst_n & (cnt < RSP_DEPTH)`. It has no combinational dependence on `rsp.rdy` or `req.vld`.
- Addressing:
  - Word index = `addr[AW+1:2]`, with `AW = $clog2(DEPTH_WORDS)`.
  - Upper address bits are ignored, so addresses alias.
  - Byte offset `off = addr[1:0]`.
- Store, applied at the accepting edge:
  - Byte enables = `(strobe << off)[3:0]`; bits shifted past byte 3 are dropped, with no wrap into the next word.
  - Write data = `data << (8*off)`.
  - Disabled bytes are left unchanged.
- Load:
  - The array is read at the accepting edge.
  - Response data = `word >> (8*off)`, zero-filled from the top.
  - Sign/zero extension stays with the requester.
- Store response: `pkt.data` = 0.
- Ordering:
  - Strictly in order.
  - A load accepted after a store to the same word returns the stored bytes.
  - Write-then-read needs no hazard logic, because only one request is accepted per cycle.
- Response path:
  - Read data passes through `RD_LAT-1` valid-tagged register stages.
  - It then enters a first-word-fall-through queue of `RSP_DEPTH` entries.
  - The queue head drives `rsp.vld`/`pkt.data`.
  - `cnt` guarantees that the queue never overflows.
- Reset (synchronous, applied at a `clk` edge with `rst_n`=0):
  - Clears `cnt`, pipeline valid bits, and queue pointers.
  - Array contents are not reset.
  - Transactions in flight at reset are discarded without a response.

## Timing
- A request accepted at the edge ending cycle N gives `rsp.vld`=1 from cycle N+`RD_LAT` if no older response is pending. Otherwise the response follows the older ones back-to-back.
- `rsp.vld`/`pkt.data` are held stable while `rsp.rdy`=0.
- Throughput:
  - One request per cycle while `cnt` < `RSP_DEPTH`.
  - With `rsp.rdy` tied high and `RSP_DEPTH` ≥ `RD_LAT`+1, requests are accepted continuously.
- Full boundary:
  - When `cnt` == `RSP_DEPTH`, `req.rdy`=0.
  - When a `rsp_hsk` occurs, `req.rdy` returns to 1 in the following cycle.
- Reset values:
  - `rsp.vld`=0.
  - `pkt.data`=0.
  - `req.rdy`=0 while `rst_n`=0, and 1 in the first cycle after release.

## Structure
- Shared package:
  - `ldst_req_pkt_t` and `ldst_rsp_pkt_t` stay in the interface package.
  - Add `LDST_STRB_W = RV_XLEN/8` there.
- The array is an inferred `logic [RV_XLEN-1:0] mem [DEPTH_WORDS]` with per-byte write enable.
- One sub-module, `ldst_rsp_fifo`: synchronous FWFT queue with parameters `DEPTH` and `WIDTH`, and ports push, pop, full, empty, din, dout.

## Test plan
- Word write/read:
  - Store addr=0x10, data=0xDEADBEEF, strobe=1111.
  - Then load addr=0x10.
  - Required: store response data 0; load response data 0xDEADBEEF; load `rsp.vld` at N+`RD_LAT`.
- Byte store with offset, after the word write above:
  - Store addr=0x13, data=0x000000A5, strobe=0001.
  - Load 0x10 → 0xA5ADBEEF.
  - Load 0x13 → 0x000000A5.
- Halfword offset and truncation:
  - Store addr=0x22, data=0x1234, strobe=0011, then load 0x20 → 0x1234xxxx, where the upper half is 0x1234 and the lower half is unchanged.
  - Store addr=0x23, strobe=0011 → only byte 3 of the word is written.
- Backpressure:
  - Hold `rsp.rdy`=0 and issue loads continuously.
  - Required: exactly `RSP_DEPTH` accepted, then `req.rdy`=0.
  - Release `rsp.rdy` → responses in issue order; `req.rdy` returns one cycle after the first `rsp_hsk`.
- Reset mid-operation:
  - Assert `rst_n`=0 for one edge with 2 outstanding transactions.
  - Required: `rsp.vld`=0, `cnt`=0, no stale responses afterwards.
  - Data stored before the reset reads back unchanged.
